// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: the FSM state encoding and PC width.
package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one fetch per PC, holds the instruction for decode, drains stale responses.
// Optional fetch timeout watchdog is enabled with `define FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int XLEN           = fetch_sequencer_pkg::XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus1,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_error
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] instr_q, instrPc_q;
  logic            instrValid_q;
  logic            timeoutHit;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: if (!redirect_valid) state_d = WAIT;
      WAIT: begin
        if (redirect_valid) state_d = imem_ack ? FETCH : DRAIN;
        else if (imem_ack)  state_d = HOLD;
      end
      HOLD:  if (redirect_valid || !stall) state_d = FETCH;
      DRAIN: if (imem_ack) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    // A timed-out fetch is retried from FETCH; any redirect this cycle still loads PC.
    if (timeoutHit) state_d = FETCH;
  end

  always_comb begin
    imem_req  = (state_q == FETCH) && !redirect_valid;
    imem_addr = pc;
    pc_ready  = redirect_valid || ((state_q == HOLD) && !stall);
    next_pc   = redirect_valid ? redirect_target : pc_plus1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q      <= '0;
      instrPc_q    <= '0;
      instrValid_q <= 1'b0;
    end else if ((state_q == WAIT) && imem_ack && !redirect_valid) begin
      instr_q      <= imem_rdata;
      instrPc_q    <= pc;
      instrValid_q <= 1'b1;
    end else if ((state_q == HOLD) && (state_d != HOLD)) begin
      instrValid_q <= 1'b0;
    end
  end

  assign instr_valid = instrValid_q;
  assign instr       = instr_q;
  assign instr_pc    = instrPc_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic             fetchError_q;
  logic             waiting;

  // The count restarts whenever WAIT/DRAIN is entered and advances only while it is held.
  always_comb begin
    waiting      = (state_q == WAIT) || (state_q == DRAIN);
    timeoutHit   = waiting && !imem_ack &&
                   (timeoutCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    timeoutCnt_d = '0;
    if (waiting && (state_d == state_q)) timeoutCnt_d = timeoutCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeoutCnt_q <= '0;
      fetchError_q <= 1'b0;
    end else begin
      timeoutCnt_q <= timeoutCnt_d;
      if (timeoutHit) fetchError_q <= 1'b1;
    end
  end

  assign fetch_error = fetchError_q;
`else
  logic unusedTimeout;

  assign timeoutHit    = 1'b0;
  assign fetch_error   = 1'b0;
  assign unusedTimeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a small PC-register model around the DUT.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  pc_t         pcReg;
  logic [31:0] pc, pc_plus1, next_pc;
  logic        pc_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        fetch_error;

  int totalChecks = 0;
  int badChecks   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_plus1(pc_plus1), .next_pc(next_pc),
    .pc_ready(pc_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fetch_error(fetch_error)
  );

  // PC register the sequencer drives through next_pc/pc_ready.
  always @(posedge clk) begin
    if (rst)           pcReg <= '0;
    else if (pc_ready) pcReg <= next_pc;
  end
  assign pc       = pcReg;
  assign pc_plus1 = pcReg + 32'd1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                               input logic stl, input logic ack,
                               input logic [31:0] rdata);
    @(negedge clk);
    redirect_valid  = redir;
    redirect_target = tgt;
    stall           = stl;
    imem_ack        = ack;
    imem_rdata      = rdata;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_instr_pc", instr_pc, 32'd0);
    checkOutput("rst_error", 32'(fetch_error), 32'd0);
    rst = 1'b0;

    // Basic 3-cycle cadence at pc 0 then pc 1
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("f0_req", 32'(imem_req), 32'd1);
    checkOutput("f0_addr", imem_addr, 32'd0);
    checkOutput("f0_pc_ready", 32'(pc_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h00000013);
    checkOutput("w0_req", 32'(imem_req), 32'd0);
    checkOutput("w0_pc_ready", 32'(pc_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("h0_valid", 32'(instr_valid), 32'd1);
    checkOutput("h0_instr", instr, 32'h00000013);
    checkOutput("h0_instr_pc", instr_pc, 32'd0);
    checkOutput("h0_pc_ready", 32'(pc_ready), 32'd1);
    checkOutput("h0_next_pc", next_pc, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("f1_valid", 32'(instr_valid), 32'd0);
    checkOutput("f1_req", 32'(imem_req), 32'd1);
    checkOutput("f1_addr", imem_addr, 32'd1);

    // Stall for 4 cycles in HOLD
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h00500093);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF);
      checkOutput("stall_valid", 32'(instr_valid), 32'd1);
      checkOutput("stall_instr", instr, 32'h00500093);
      checkOutput("stall_instr_pc", instr_pc, 32'd1);
      checkOutput("stall_pc_ready", 32'(pc_ready), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("unstall_pc_ready", 32'(pc_ready), 32'd1);
    checkOutput("unstall_next_pc", next_pc, 32'd2);

    // Redirect in WAIT, stale ack three cycles later
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("f2_addr", imem_addr, 32'd2);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'd0);
    checkOutput("rw_pc_ready", 32'(pc_ready), 32'd1);
    checkOutput("rw_next_pc", next_pc, 32'h40);
    checkOutput("rw_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("drain1_req", 32'(imem_req), 32'd0);
    checkOutput("drain1_pc_ready", 32'(pc_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("drain2_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    checkOutput("drain_ack_valid", 32'(instr_valid), 32'd0);
    checkOutput("drain_ack_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("post_drain_valid", 32'(instr_valid), 32'd0);
    checkOutput("post_drain_req", 32'(imem_req), 32'd1);
    checkOutput("post_drain_addr", imem_addr, 32'h40);

    // Redirect coinciding with ack in WAIT
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 32'hCAFEF00D);
    checkOutput("ra_pc_ready", 32'(pc_ready), 32'd1);
    checkOutput("ra_next_pc", next_pc, 32'h80);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("ra_valid", 32'(instr_valid), 32'd0);
    checkOutput("ra_req", 32'(imem_req), 32'd1);
    checkOutput("ra_addr", imem_addr, 32'h80);

    // Redirect while HOLD and stalled
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h11111111);
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'd0);
    checkOutput("rh_valid", 32'(instr_valid), 32'd1);
    checkOutput("rh_instr_pc", instr_pc, 32'h80);
    checkOutput("rh_pc_ready", 32'(pc_ready), 32'd1);
    checkOutput("rh_next_pc", next_pc, 32'h20);
    // Ack in FETCH is ignored
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h22222222);
    checkOutput("rh_fall_valid", 32'(instr_valid), 32'd0);
    checkOutput("rh_req", 32'(imem_req), 32'd1);
    checkOutput("rh_addr", imem_addr, 32'h20);

`ifdef FETCH_TIMEOUT_EN
    // No ack: four WAIT cycles then a retry at the same pc
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkOutput("to_wait_valid", 32'(instr_valid), 32'd0);
      checkOutput("to_wait_error", 32'(fetch_error), 32'd0);
      checkOutput("to_wait_req", 32'(imem_req), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("to_error", 32'(fetch_error), 32'd1);
    checkOutput("to_retry_req", 32'(imem_req), 32'd1);
    checkOutput("to_retry_addr", imem_addr, 32'h20);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h33333333);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("to_instr", instr, 32'h33333333);
    checkOutput("to_sticky", 32'(fetch_error), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("to_sticky2", 32'(fetch_error), 32'd1);
`else
    // Without the watchdog WAIT persists indefinitely
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkOutput("nto_req", 32'(imem_req), 32'd0);
      checkOutput("nto_error", 32'(fetch_error), 32'd0);
      checkOutput("nto_valid", 32'(instr_valid), 32'd0);
    end
`endif

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst2_error", 32'(fetch_error), 32'd0);
    checkOutput("rst2_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst2_req", 32'(imem_req), 32'd1);
    checkOutput("rst2_addr", imem_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
